wb_serial_master: RTL and testbench
===================================

Name: wb_serial_master

Overview:
- Wishbone initiator driven by a byte-stream command channel.
- Lets an external host reach the multiplexer's Wishbone slave registers without the management SoC, e.g. for bring-up and debug through IO pads.
- Byte stream arrives from a separate UART/SPI receiver. Responses go to a matching transmitter.
- Runs on the Wishbone clock domain. One transaction is in flight at a time.

Parameters:
TIMEOUT, 255, max cycles waiting for wbm_ack_i before abort (1..2^TIMEOUT_W-1)
TIMEOUT_W, 8, width of timeout counter

Ports:
wb_clk_i  in  1  sole clock, rising edge
rst_n  in  1  synchronous active-low reset
rx_data  in  8  command byte from receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts byte; transfer when rx_valid&&rx_ready
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte; transfer when tx_valid&&tx_ready
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  1=write, 0=read
wbm_sel_o  out  4  byte selects
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data
wbm_ack_i  in  1  slave acknowledge
wbm_dat_i  in  32  read data
busy  out  1  high whenever state != IDLE

Behaviour:
Reset (rst_n low at a rising edge):
- Next state IDLE. Zeroes all outputs: rx_ready, tx_valid, tx_data, cyc, stb, we, sel, adr, dat_o, busy.
- Applies mid-frame or mid-bus-cycle too: partial frame discarded, cyc/stb dropped immediately, pending response discarded.
- After reset release: rx_ready=1 on the first cycle.

Frame format:
- Opcode byte first: 0x01 = read, 0x02 = write.
- Then 4 address bytes, MSB first.
- Write only: then 4 data bytes, MSB first.

States:
- IDLE: rx_ready=1. On accept:
  - 0x01 -> ADDR, we=0.
  - 0x02 -> ADDR, we=1.
  - Other -> RESP with single byte 0xEF.
- ADDR: rx_ready=1. Shifts bytes into wbm_adr_o.
  - After the 4th byte: write -> WDATA; read -> BUS.
- WDATA: rx_ready=1. Shifts bytes into wbm_dat_o. After the 4th byte -> BUS.
- BUS:
  - rx_ready=0. cyc=stb=1, sel=4'hF, asserted the cycle after the last frame byte is accepted.
  - Timeout counter cleared on entry and incremented each BUS cycle.
  - wbm_ack_i sampled high:
    - Read: capture wbm_dat_i. Response = 4 data bytes, MSB first.
    - Write: response = 0xA5.
    - cyc/stb low the following cycle; -> RESP.
  - Counter reaches TIMEOUT with no ack: cyc/stb low next cycle; response = 0xEE (single byte, read or write); -> RESP.
  - Ack in the same cycle as timeout: ack wins.
- RESP:
  - rx_ready=0. tx_valid=1, tx_data = current response byte.
  - tx_data is stable until accepted. Advances one byte per accepted transfer.
  - After the last byte is accepted: tx_valid=0 next cycle; -> IDLE.
  - Zero-wait back-to-back acceptance is supported.

Held values and ordering:
- adr, dat_o and we hold their values after a transaction until overwritten by the next frame.
- Bytes presented while rx_ready=0 are not consumed; the upstream source holds them.
- The earliest the first response byte is valid is 1 cycle after ack.
- Minimum write latency is last rx byte -> cyc high: 1 cycle.

Test Plan:
1. Write frame 02 30 00 00 04 DE AD BE EF; slave acks 2 cycles after stb -> one bus cycle, we=1, adr=0x30000004, dat_o=0xDEADBEEF, sel=F, cyc held 3 cycles; response exactly one byte 0xA5; busy then returns 0.
2. Read frame 01 30 00 00 08; slave returns 0x12345678 with ack -> tx bytes 12,34,56,78 in order. tx_ready toggles low mid-stream; tx_data stays stable while stalled.
3. Read with no ack, TIMEOUT=255 -> cyc/stb high exactly 255 cycles then low; single response 0xEE; next frame proceeds normally.
4. Opcode 0x7F -> no bus activity, response 0xEF, back to IDLE. Ack arriving exactly on the timeout cycle -> normal response, not 0xEE.
5. rst_n low for one cycle after 3 address bytes, and again while cyc=1 -> all outputs 0 next cycle. A new full write frame after reset executes with the correct address; no stale bytes are mixed in.
6. Back-to-back frames with rx_valid held high continuously -> rx_ready drops during BUS/RESP. No byte is lost or duplicated across 10 random read/write frames checked against a scoreboard.

Source files
------------

// File: rtl/wb_serial_master.sv
// wb_serial_master
// Wishbone initiator fed by a byte-stream command channel. A host sends a
// frame (opcode, 4 address bytes MSB first, and for writes 4 data bytes MSB
// first). The block runs one Wishbone cycle and returns a response stream:
//   read ok   -> 4 data bytes MSB first
//   write ok  -> 0xA5
//   timeout   -> 0xEE
//   bad opcode-> 0xEF
// Ports:
//   wb_clk_i, rst_n          clock, synchronous active-low reset
//   rx_data/rx_valid/rx_ready command byte stream in (valid/ready)
//   tx_data/tx_valid/tx_ready response byte stream out (valid/ready)
//   wbm_*                    Wishbone initiator port
//   busy                     high whenever the engine is not idle
// All outputs are registered.
module wb_serial_master #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] RSP_WR   = 8'hA5;
    localparam logic [7:0] RSP_TMO  = 8'hEE;
    localparam logic [7:0] RSP_BAD  = 8'hEF;
    // The counter holds the number of completed BUS cycles, so the cycle in
    // which it equals TIMEOUT-1 is the TIMEOUT-th and last one.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state_r,     state_s;
    logic [1:0]           byte_cnt_r,  byte_cnt_s;
    logic [TIMEOUT_W-1:0] tmo_cnt_r,   tmo_cnt_s;
    logic [31:0]          resp_r,      resp_s;       // bytes still to send after tx_data
    logic [1:0]           resp_left_r, resp_left_s;  // count of those bytes
    logic                 rx_ready_r,  rx_ready_s;
    logic                 tx_valid_r,  tx_valid_s;
    logic [7:0]           tx_data_r,   tx_data_s;
    logic                 cyc_r,       cyc_s;
    logic                 stb_r,       stb_s;
    logic                 we_r,        we_s;
    logic [3:0]           sel_r,       sel_s;
    logic [31:0]          adr_r,       adr_s;
    logic [31:0]          dat_r,       dat_s;
    logic                 busy_r,      busy_s;
    logic                 rx_fire_s;
    logic                 tx_fire_s;

    assign rx_fire_s = rx_valid & rx_ready_r;
    assign tx_fire_s = tx_valid_r & tx_ready;

    // Next-state and next-output logic for the frame/bus/response engine
    always_comb begin
        state_s     = state_r;
        byte_cnt_s  = byte_cnt_r;
        tmo_cnt_s   = tmo_cnt_r;
        resp_s      = resp_r;
        resp_left_s = resp_left_r;
        tx_valid_s  = tx_valid_r;
        tx_data_s   = tx_data_r;
        cyc_s       = cyc_r;
        stb_s       = stb_r;
        we_s        = we_r;
        sel_s       = sel_r;
        adr_s       = adr_r;
        dat_s       = dat_r;

        case (state_r)
            ST_IDLE: begin
                if (rx_fire_s) begin
                    byte_cnt_s = 2'd0;
                    case (rx_data)
                        OP_READ: begin
                            we_s    = 1'b0;
                            state_s = ST_ADDR;
                        end
                        OP_WRITE: begin
                            we_s    = 1'b1;
                            state_s = ST_ADDR;
                        end
                        default: begin
                            state_s     = ST_RESP;
                            tx_valid_s  = 1'b1;
                            tx_data_s   = RSP_BAD;
                            resp_left_s = 2'd0;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                if (rx_fire_s) begin
                    adr_s      = {adr_r[23:0], rx_data};
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        if (we_r) begin
                            state_s = ST_WDATA;
                        end else begin
                            state_s   = ST_BUS;
                            cyc_s     = 1'b1;
                            stb_s     = 1'b1;
                            sel_s     = 4'hF;
                            tmo_cnt_s = '0;
                        end
                    end else begin
                        state_s = ST_ADDR;
                    end
                end else begin
                    state_s = ST_ADDR;
                end
            end

            ST_WDATA: begin
                if (rx_fire_s) begin
                    dat_s      = {dat_r[23:0], rx_data};
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        state_s   = ST_BUS;
                        cyc_s     = 1'b1;
                        stb_s     = 1'b1;
                        sel_s     = 4'hF;
                        tmo_cnt_s = '0;
                    end else begin
                        state_s = ST_WDATA;
                    end
                end else begin
                    state_s = ST_WDATA;
                end
            end

            ST_BUS: begin
                // Ack is tested first so it wins over a simultaneous timeout.
                if (wbm_ack_i) begin
                    cyc_s      = 1'b0;
                    stb_s      = 1'b0;
                    sel_s      = 4'h0;
                    state_s    = ST_RESP;
                    tx_valid_s = 1'b1;
                    if (we_r) begin
                        tx_data_s   = RSP_WR;
                        resp_left_s = 2'd0;
                    end else begin
                        tx_data_s   = wbm_dat_i[31:24];
                        resp_s      = {wbm_dat_i[23:0], 8'h00};
                        resp_left_s = 2'd3;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    cyc_s       = 1'b0;
                    stb_s       = 1'b0;
                    sel_s       = 4'h0;
                    state_s     = ST_RESP;
                    tx_valid_s  = 1'b1;
                    tx_data_s   = RSP_TMO;
                    resp_left_s = 2'd0;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TIMEOUT_W'(1);
                end
            end

            ST_RESP: begin
                if (tx_fire_s) begin
                    if (resp_left_r == 2'd0) begin
                        tx_valid_s = 1'b0;
                        state_s    = ST_IDLE;
                    end else begin
                        tx_data_s   = resp_r[31:24];
                        resp_s      = {resp_r[23:0], 8'h00};
                        resp_left_s = resp_left_r - 2'd1;
                    end
                end else begin
                    state_s = ST_RESP;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                tx_valid_s = 1'b0;
                cyc_s      = 1'b0;
                stb_s      = 1'b0;
                sel_s      = 4'h0;
            end
        endcase

        // Byte intake is open only while a frame can still be collected.
        rx_ready_s = (state_s == ST_IDLE) || (state_s == ST_ADDR) || (state_s == ST_WDATA);
        busy_s     = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= 2'd0;
            tmo_cnt_r   <= '0;
            resp_r      <= 32'h0000_0000;
            resp_left_r <= 2'd0;
            rx_ready_r  <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= 4'h0;
            adr_r       <= 32'h0000_0000;
            dat_r       <= 32'h0000_0000;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            byte_cnt_r  <= byte_cnt_s;
            tmo_cnt_r   <= tmo_cnt_s;
            resp_r      <= resp_s;
            resp_left_r <= resp_left_s;
            rx_ready_r  <= rx_ready_s;
            tx_valid_r  <= tx_valid_s;
            tx_data_r   <= tx_data_s;
            cyc_r       <= cyc_s;
            stb_r       <= stb_s;
            we_r        <= we_s;
            sel_r       <= sel_s;
            adr_r       <= adr_s;
            dat_r       <= dat_s;
            busy_r      <= busy_s;
        end
    end

    assign rx_ready  = rx_ready_r;
    assign tx_valid  = tx_valid_r;
    assign tx_data   = tx_data_r;
    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = stb_r;
    assign wbm_we_o  = we_r;
    assign wbm_sel_o = sel_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_wb_serial_master.sv
// Testbench for wb_serial_master: frames are built from the protocol rules,
// expected bus cycles and response bytes are queued by a frame-level model,
// and a monitor compares DUT activity against those queues.
module tb_wb_serial_master;

    localparam int TMO = 255;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    wb_serial_master #(.TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          ack;   // cycle index (from cyc rise) of ack, -1 = never
        logic [31:0] rd;
        int          len;   // expected number of cycles with cyc high
    } bus_t;

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    bus_t       bus_q[$];
    bus_t       cur;
    logic       cyc_prev;
    int         cyc_cnt;
    int         rx_acc;
    bit         tx_rand;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: bytes on the wire, bus cycle and response.
    task automatic send_frame(input logic [7:0] op, input logic [31:0] adr,
                              input logic [31:0] dat, input int ack, input logic [31:0] rd);
        bus_t b;
        bit   acked;
        rx_q.push_back(op);
        if (op == 8'h01 || op == 8'h02) begin
            for (int i = 3; i >= 0; i--) rx_q.push_back(adr[8*i +: 8]);
            if (op == 8'h02) for (int i = 3; i >= 0; i--) rx_q.push_back(dat[8*i +: 8]);
            acked = (ack >= 0) && (ack < TMO);
            b.we  = (op == 8'h02);
            b.adr = adr;
            b.dat = dat;
            b.ack = ack;
            b.rd  = rd;
            b.len = acked ? ack + 1 : TMO;
            bus_q.push_back(b);
            if (!acked) exp_tx.push_back(8'hEE);
            else if (b.we) exp_tx.push_back(8'hA5);
            else for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
        end else begin
            exp_tx.push_back(8'hEF);
        end
    endtask

    // One clock: account the handshakes of this edge, monitor, then drive.
    task automatic tick();
        bit         rf;
        bit         tf;
        bit         tv_prev;
        logic [7:0] td_prev;
        logic [7:0] e;
        rf      = rst_n && rx_valid && rx_ready;
        tf      = rst_n && tx_valid && tx_ready;
        tv_prev = tx_valid;
        td_prev = tx_data;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (rf) begin
                void'(rx_q.pop_front());
                rx_acc++;
            end
            if (tf) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", {56'd0, td_prev}, 64'hFFFF);
                else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", {56'd0, td_prev}, {56'd0, e});
                end
            end
            if (tv_prev && !tf) chk("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, td_prev});
            if (wbm_cyc_o && !cyc_prev) begin
                cyc_cnt = 0;
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 64'd1, 64'd0);
                    cur.ack = -1;
                    cur.len = TMO;
                end else begin
                    cur = bus_q.pop_front();
                    chk("bus_we",  {63'd0, wbm_we_o}, {63'd0, cur.we});
                    chk("bus_adr", {32'd0, wbm_adr_o}, {32'd0, cur.adr});
                    chk("bus_sel_stb", {59'd0, wbm_sel_o, wbm_stb_o}, {59'd0, 4'hF, 1'b1});
                    if (cur.we) chk("bus_dat", {32'd0, wbm_dat_o}, {32'd0, cur.dat});
                end
            end
            if (cyc_prev && !wbm_cyc_o) chk("cyc_len", 64'(cyc_cnt), 64'(cur.len));
            if (wbm_cyc_o) begin
                cyc_cnt++;
                chk("rx_ready_in_bus", {63'd0, rx_ready}, 64'd0);
            end
            if (tx_valid) chk("rx_ready_in_resp", {63'd0, rx_ready}, 64'd0);
            cyc_prev = wbm_cyc_o;
        end
        rx_valid  = rst_n && (rx_q.size() > 0);
        rx_data   = rx_valid ? rx_q[0] : 8'($urandom);
        tx_ready  = tx_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        wbm_ack_i = rst_n && wbm_cyc_o && (cyc_cnt - 1 == cur.ack);
        wbm_dat_i = wbm_ack_i ? cur.rd : $urandom;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() > 0 || exp_tx.size() > 0 || bus_q.size() > 0 || busy || tx_valid)
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_drain_timeout"}, 64'd1, 64'd0);
        tick();
        chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        rx_q.delete();
        exp_tx.delete();
        bus_q.delete();
        tick();
        chk({tag, "_outputs_zero"},
            {1'b0, rx_ready, tx_valid, tx_data, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy},
            64'd0);
        chk({tag, "_adr_dat_zero"}, {wbm_adr_o, wbm_dat_o}, 64'd0);
        rst_n    = 1'b1;
        cyc_prev = 1'b0;
        cyc_cnt  = 0;
        cur.ack  = -1;
        tick();
        chk({tag, "_ready_after"}, {62'd0, rx_ready, busy}, {62'd0, 1'b1, 1'b0});
    endtask

    initial begin
        int n;
        n_checks  = 0;
        n_fail    = 0;
        rx_acc    = 0;
        cyc_prev  = 1'b0;
        cyc_cnt   = 0;
        cur.ack   = -1;
        cur.len   = 0;
        tx_rand   = 1'b0;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b1;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        tick();
        do_reset("rst0");

        // 1: write, ack 2 cycles after stb -> cyc high 3 cycles, response A5
        send_frame(8'h02, 32'h3000_0004, 32'hDEAD_BEEF, 2, 32'h0);
        drain("t1", 200);

        // 2: read with stalling transmitter
        tx_rand = 1'b1;
        send_frame(8'h01, 32'h3000_0008, 32'h0, 0, 32'h1234_5678);
        send_frame(8'h01, 32'h3000_000C, 32'h0, 3, 32'hCAFE_F00D);
        drain("t2", 400);
        tx_rand = 1'b0;

        // 3: read with no ack -> timeout EE, then a normal frame
        send_frame(8'h01, 32'h0000_0010, 32'h0, -1, 32'h0);
        send_frame(8'h02, 32'h0000_0014, 32'h0102_0304, 1, 32'h0);
        drain("t3", 800);

        // 4: bad opcode, then ack on the last timeout cycle (write and read)
        send_frame(8'h7F, 32'h0, 32'h0, 0, 32'h0);
        send_frame(8'h02, 32'h0000_0020, 32'h5555_AAAA, TMO - 1, 32'h0);
        send_frame(8'h01, 32'h0000_0024, 32'h0, TMO - 1, 32'h8765_4321);
        drain("t4", 1500);

        // 5a: reset after opcode + 3 address bytes
        rx_acc = 0;
        send_frame(8'h02, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 0, 32'h0);
        n = 0;
        while (rx_acc < 4 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("t5a_wait_bytes", 64'd1, 64'd0);
        do_reset("t5a");
        send_frame(8'h02, 32'h4000_0044, 32'h1111_2222, 1, 32'h0);
        drain("t5a", 200);

        // 5b: reset while cyc is high
        send_frame(8'h01, 32'h5000_0050, 32'h0, -1, 32'h0);
        n = 0;
        while (!wbm_cyc_o && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("t5b_wait_cyc", 64'd1, 64'd0);
        tick();
        tick();
        do_reset("t5b");
        send_frame(8'h02, 32'h6000_0060, 32'h3333_4444, 0, 32'h0);
        drain("t5b", 200);

        // 6: ten back-to-back random frames with rx_valid held high
        tx_rand = 1'b1;
        for (int f = 0; f < 10; f++) begin
            send_frame(($urandom_range(0, 1) != 0) ? 8'h02 : 8'h01,
                       $urandom, $urandom, $urandom_range(0, 6), $urandom);
        end
        drain("t6", 2000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
